// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter family.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  // Loads above the top of the count range land on MOD-1.
  function automatic int unsigned clamp_load(input int unsigned value,
                                             input int unsigned mod);
    return (value <= mod - 1) ? value : mod - 1;
  endfunction

endpackage

// File: rtl/updown_mod_counter.sv
// Up/down modulo-MOD counter with load, count enable and wrap/saturate mode.
// Latency: count, wrap update one clock_div edge after inputs; at_max/at_min follow count directly.
// Backpressure: none; every edge is accepted, enable=0 simply holds the count.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 16
) (
  input  logic             clock_div,
  input  logic             reset,
  input  logic             enable,
  input  logic             Up_Down,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MOD - 1);
  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

  // State is held one bit wider so increments never alias modulo 2**WIDTH.
  logic [WIDTH:0] count_q;
  logic [WIDTH:0] next_count;
  logic           next_wrap;

  always_comb begin
    next_count = count_q;
    next_wrap  = 1'b0;
    if (load) begin
      next_count = (WIDTH+1)'(clamp_load(32'(load_value), MOD));
    end else if (enable) begin
      if (Up_Down == DIR_UP) begin
        if (count_q >= MAX_EXT) begin
          if (sat_mode == MODE_SAT) begin
            next_count = MAX_EXT;
          end else begin
            next_count = '0;
            next_wrap  = 1'b1;
          end
        end else begin
          next_count = count_q + ONE_EXT;
        end
      end else begin
        if (count_q == '0) begin
          if (sat_mode == MODE_SAT) begin
            next_count = '0;
          end else begin
            next_count = MAX_EXT;
            next_wrap  = 1'b1;
          end
        end else begin
          next_count = count_q - ONE_EXT;
        end
      end
    end
  end

  always_ff @(posedge clock_div) begin
    if (reset) begin
      count_q <= '0;
      wrap    <= 1'b0;
    end else begin
      count_q <= next_count;
      wrap    <= next_wrap;
    end
  end

  assign count  = count_q[WIDTH-1:0];
  assign at_max = (count_q == MAX_EXT);
  assign at_min = (count_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed vector bench for updown_mod_counter at MOD=10, MOD=16 and MOD=2.
module tb_updown_mod_counter;

  logic       clock_div = 1'b0;
  logic       reset, enable, Up_Down, sat_mode, load;
  logic [3:0] load_value;

  logic [3:0] count10, count16, count2;
  logic       wrap10, wrap16, wrap2;
  logic       max10, max16, max2;
  logic       min10, min16, min2;

  int checks = 0;
  int errors = 0;

  always #5 clock_div = ~clock_div;

  updown_mod_counter #(.WIDTH(4), .MOD(10)) dut10 (
    .clock_div(clock_div), .reset(reset), .enable(enable), .Up_Down(Up_Down),
    .sat_mode(sat_mode), .load(load), .load_value(load_value),
    .count(count10), .wrap(wrap10), .at_max(max10), .at_min(min10));

  updown_mod_counter #(.WIDTH(4), .MOD(16)) dut16 (
    .clock_div(clock_div), .reset(reset), .enable(enable), .Up_Down(Up_Down),
    .sat_mode(sat_mode), .load(load), .load_value(load_value),
    .count(count16), .wrap(wrap16), .at_max(max16), .at_min(min16));

  updown_mod_counter #(.WIDTH(4), .MOD(2)) dut2 (
    .clock_div(clock_div), .reset(reset), .enable(enable), .Up_Down(Up_Down),
    .sat_mode(sat_mode), .load(load), .load_value(load_value),
    .count(count2), .wrap(wrap2), .at_max(max2), .at_min(min2));

  typedef struct {
    logic       rst, ld, en, ud, sat;
    logic [3:0] lv;
    logic [3:0] exp_count;
    logic       exp_wrap, exp_max, exp_min;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic ld, logic en, logic ud, logic sat,
                              logic [3:0] lv, logic [3:0] c, logic w);
    vec_t r;
    r.rst = rst; r.ld = ld; r.en = en; r.ud = ud; r.sat = sat; r.lv = lv;
    r.exp_count = c; r.exp_wrap = w;
    r.exp_max = (c == 4'd9);
    r.exp_min = (c == 4'd0);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ld, input logic en,
                       input logic ud, input logic sat, input logic [3:0] lv);
    @(negedge clock_div);
    reset = rst; load = ld; enable = en; Up_Down = ud; sat_mode = sat; load_value = lv;
    @(posedge clock_div);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; Up_Down = 1'b1; sat_mode = 1'b0;
    load = 1'b0; load_value = 4'd0;

    // Reset state.
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
    // Count up in wrap mode: 1..9, 0 (wrap), 1, 2.
    for (int i = 1; i <= 12; i++)
      vecs.push_back(mk(0, 0, 1, 1, 0, 0, 4'(i % 10), (i == 10)));
    // Load 3, count down through the lower bound.
    vecs.push_back(mk(0, 1, 0, 0, 0, 3, 3, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 9, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 8, 0));
    // Saturate mode: load 8, up 4 edges pins at 9, down 10 edges pins at 0.
    vecs.push_back(mk(0, 1, 0, 1, 1, 8, 8, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 1, 1, 1, 0, 9, 0));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0, 0, 1, 0, 1, 0, 4'((i < 9) ? 8 - i : 0), 0));
    // Clamped load, and load beating enable.
    vecs.push_back(mk(0, 1, 0, 1, 0, 13, 9, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 5, 5, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 6, 0));
    // Reset beats a simultaneous load, then enable=0 holds.
    vecs.push_back(mk(1, 1, 1, 1, 0, 7, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    // A pending wrap pulse is cleared by load, by enable=0 and by reset.
    vecs.push_back(mk(0, 1, 0, 1, 0, 9, 9, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 2, 2, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 9, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 9, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].ud, vecs[i].sat, vecs[i].lv);
      check($sformatf("v%0d count", i), int'(count10), int'(vecs[i].exp_count));
      check($sformatf("v%0d wrap", i), int'(wrap10), int'(vecs[i].exp_wrap));
      check($sformatf("v%0d at_max", i), int'(max10), int'(vecs[i].exp_max));
      check($sformatf("v%0d at_min", i), int'(min10), int'(vecs[i].exp_min));
    end

    // Modulus 2: continuous up toggles, wrap on each 1->0.
    drive(1, 0, 0, 1, 0, 0);
    check("m2 reset count", int'(count2), 0);
    check("m2 reset min", int'(min2), 1);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 1, 1, 0, 0);
      check($sformatf("m2 up%0d count", i), int'(count2), i % 2);
      check($sformatf("m2 up%0d wrap", i), int'(wrap2), int'(i % 2 == 0));
      check($sformatf("m2 up%0d max", i), int'(max2), i % 2);
    end
    // Modulus 2 alternating down/up: every edge wraps, wrap stays high.
    drive(0, 0, 1, 0, 0, 0);
    check("m2 dn count", int'(count2), 1);
    check("m2 dn wrap", int'(wrap2), 1);
    drive(0, 0, 1, 1, 0, 0);
    check("m2 up count", int'(count2), 0);
    check("m2 up wrap", int'(wrap2), 1);
    drive(0, 1, 0, 1, 0, 15);
    check("m2 clamp", int'(count2), 1);

    // Modulus 16: full-range overflow wraps cleanly.
    check("m16 load15", int'(count16), 15);
    check("m16 at_max", int'(max16), 1);
    drive(0, 0, 1, 1, 0, 0);
    check("m16 wrap count", int'(count16), 0);
    check("m16 wrap pulse", int'(wrap16), 1);
    check("m16 at_min", int'(min16), 1);
    drive(0, 0, 1, 1, 0, 0);
    check("m16 next count", int'(count16), 1);
    check("m16 pulse end", int'(wrap16), 0);
    drive(0, 1, 0, 0, 1, 15);
    drive(0, 0, 1, 1, 1, 0);
    check("m16 sat count", int'(count16), 15);
    check("m16 sat wrap", int'(wrap16), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
